shiftreg_out_ctl: RTL and testbench
===================================

// Module: shiftreg_out_ctl
// PURPOSE
// Serial-in/parallel-out driver (74HC595-style), the write-direction counterpart
// of shiftregctl's button reader. Accepts a WIDTH-bit word over a valid/ready
// handshake, shifts it out MSB-first with a divided serial clock, then pulses the
// storage latch so all parallel outputs (LEDs, relays) update at once.
// PARAMETERS
// WIDTH    16  bits per frame (number of chained register outputs), >=1
// CLK_DIV  4   clk cycles per serial-clock half-period, >=1
// PORTS
// clk             in   1      system clock
// reset           in   1      asynchronous, active-high reset
// data_in         in   WIDTH  word to send; sampled only on accept
// data_valid      in   1      producer has a word
// data_ready      out  1      block can accept a word (high only in IDLE)
// frame_done      out  1      one-cycle pulse when a frame's latch completes
// shiftreg_clk    out  1      serial clock (SRCLK); chip samples on rising edge
// shiftreg_data   out  1      serial data (SER)
// shiftreg_latch  out  1      storage latch (RCLK), active high
// shiftreg_oen    out  1      output enable, active low
// BEHAVIOUR
// - Reset values: data_ready=1 after release, frame_done=0, shiftreg_clk=0,
//   shiftreg_data=0, shiftreg_latch=0, shiftreg_oen=1; FSM=IDLE, counters=0.
// - All outputs registered. States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
// - IDLE: data_ready=1. Accept = data_valid&&data_ready at a clk edge: capture
//   data_in to shadow reg, bit index=WIDTH-1, ->SHIFT_LO. No accept -> stay.
// - SHIFT_LO (CLK_DIV cycles): shiftreg_clk=0, shiftreg_data=shadow[index],
//   valid from the first cycle after accept (setup = CLK_DIV cycles). ->SHIFT_HI.
// - SHIFT_HI (CLK_DIV cycles): shiftreg_clk=1, data held stable. At end:
//   index>0 -> index-1, ->SHIFT_LO; index==0 -> LATCH.
// - LATCH (CLK_DIV cycles): shiftreg_clk=0, shiftreg_latch=1, data=0. At end:
//   latch=0, frame_done=1 for exactly one cycle, shiftreg_oen=0, ->IDLE.
// - Frame length accept->IDLE = WIDTH*2*CLK_DIV + CLK_DIV cycles
//   (16,4 -> 132). data_ready low for that whole span; back-to-back accept
//   legal on the first IDLE cycle (same cycle frame_done is high).
// - data_in/data_valid changes after accept are ignored; no internal queue.
// - Half-period counter width $clog2(CLK_DIV+1); bit index width $clog2(WIDTH+1);
//   no wrap: counter reloads to 0 on every state change.
// - shiftreg_oen stays 1 from reset until the first LATCH ends, then 0 until
//   next reset, so power-up garbage in the chip is never driven.
// - Reset mid-frame (any state): immediate return to reset values, frame
//   discarded, no latch pulse, shiftreg_oen back to 1.
// - CLK_DIV=1: serial clock = clk/2, every state lasts one cycle.
// - WIDTH=1: exactly one SHIFT_LO/SHIFT_HI pair then LATCH.
// TESTING
// 1. WIDTH=16,CLK_DIV=4: send 16'hA5C3 -> 16 rising SRCLK edges sample bits
//    1010_0101_1100_0011 MSB first; one latch pulse 4 cycles wide; ready
//    returns 132 cycles after accept; model 595 parallel out = 16'hA5C3.
// 2. After reset, oen=1 through first frame; drops to 0 on cycle frame_done=1
//    and stays 0 over frames 16'h0000, 16'hFFFF.
// 3. data_valid held high with 16'h0001 then 16'h8000: back-to-back frames,
//    accept on frame_done cycle, no idle gap, model shows 0001 then 8000;
//    data_in toggling mid-frame does not alter transmitted bits.
// 4. Assert reset in SHIFT_HI of bit 7 -> next cycle clk/data/latch=0,
//    oen=1, ready=1; no latch pulse; next frame 16'h1234 latches correctly.
// 5. CLK_DIV=1, WIDTH=8, send 8'h81 -> SRCLK = clk/2, frame 17 cycles,
//    model output 8'h81; data stable across each rising SRCLK edge.
// 6. data_valid low for 50 cycles in IDLE -> all outputs static, no pulses.

Source files
------------

// File: rtl/shiftreg_out_ctl.sv
// Serial-in/parallel-out driver for a 74HC595-style chain: shifts a word out MSB-first
// on a divided serial clock, then pulses the storage latch so all outputs update together.
module shiftreg_out_ctl #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             frame_done,
  output logic             shiftreg_clk,
  output logic             shiftreg_data,
  output logic             shiftreg_latch,
  output logic             shiftreg_oen
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntLast = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IdxTop  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             latch_q, latch_d;
  logic             oen_q, oen_d;
  logic             halfDone;

  assign halfDone = (cnt_q == CntLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      latch_q  <= 1'b0;
      oen_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      latch_q  <= latch_d;
      oen_q    <= oen_d;
    end
  end

  // The shadow register shifts left per bit, so the bit on the wire is always its MSB.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (data_valid && ready_q) begin
          shadow_d = data_in;
          idx_d    = IdxTop;
          cnt_d    = '0;
          state_d  = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (halfDone) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (halfDone) begin
          cnt_d = '0;
          if (idx_q != '0) begin
            idx_d    = idx_q - 1'b1;
            shadow_d = shadow_q << 1;
            state_d  = SHIFT_LO;
          end else begin
            state_d = LATCH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (halfDone) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    ready_d = (state_d == IDLE);
    sclk_d  = (state_d == SHIFT_HI);
    latch_d = (state_d == LATCH);
    sdata_d = 1'b0;
    if (state_d == SHIFT_LO || state_d == SHIFT_HI) begin
      sdata_d = shadow_d[WIDTH-1];
    end
    done_d = (state_q == LATCH) && halfDone;
    oen_d  = oen_q && !done_d;
  end

  assign data_ready     = ready_q;
  assign frame_done     = done_q;
  assign shiftreg_clk   = sclk_q;
  assign shiftreg_data  = sdata_q;
  assign shiftreg_latch = latch_q;
  assign shiftreg_oen   = oen_q;

endmodule

// File: tb/tb_shiftreg_out_ctl.sv
// Bench for shiftreg_out_ctl: a behavioural 595 chip model watches the serial pins
// of a 16-bit/div-4 instance and an 8-bit/div-1 instance.
module tb_shiftreg_out_ctl;

  localparam int WA = 16;
  localparam int DA = 4;
  localparam int WB = 8;
  localparam int DB = 1;
  localparam int FrameA = WA * 2 * DA + DA;
  localparam int FrameB = WB * 2 * DB + DB;

  typedef struct {
    logic [15:0] word;
    logic [15:0] expPar;
    int          expCycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dataInA = '0;
  logic        validA = 1'b0;
  logic [7:0]  dataInB = '0;
  logic        validB = 1'b0;
  logic aReady, aDone, aSclk, aSdata, aLatch, aOen;
  logic bReady, bDone, bSclk, bSdata, bLatch, bOen;

  int compared = 0;
  int mismatched = 0;

  logic [5:0]  prevS[2];
  logic [15:0] chipSr[2];
  logic [15:0] parOut[2];
  int rises[2];
  int gap[2];
  int latchW[2];
  int latchPulses[2];
  int framesDone[2];

  shiftreg_out_ctl #(.WIDTH(WA), .CLK_DIV(DA)) dutA (
    .clk(clk), .reset(reset), .data_in(dataInA), .data_valid(validA),
    .data_ready(aReady), .frame_done(aDone), .shiftreg_clk(aSclk),
    .shiftreg_data(aSdata), .shiftreg_latch(aLatch), .shiftreg_oen(aOen)
  );

  shiftreg_out_ctl #(.WIDTH(WB), .CLK_DIV(DB)) dutB (
    .clk(clk), .reset(reset), .data_in(dataInB), .data_valid(validB),
    .data_ready(bReady), .frame_done(bDone), .shiftreg_clk(bSclk),
    .shiftreg_data(bSdata), .shiftreg_latch(bLatch), .shiftreg_oen(bOen)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  function automatic int widthOf(input int d);
    return (d == 0) ? WA : WB;
  endfunction

  function automatic int divOf(input int d);
    return (d == 0) ? DA : DB;
  endfunction

  // Chip model: shift on SRCLK rise, copy to parallel outputs on RCLK rise.
  always @(negedge clk) begin
    logic [5:0]  s;
    logic [15:0] mask;
    logic        latchRose, latchFell;
    for (int d = 0; d < 2; d++) begin
      s = (d == 0) ? {aReady, aDone, aSclk, aSdata, aLatch, aOen}
                   : {bReady, bDone, bSclk, bSdata, bLatch, bOen};
      if (reset) begin
        rises[d] = 0;
        gap[d] = 0;
        latchW[d] = 0;
        framesDone[d] = 0;
      end else begin
        gap[d]++;
        if (s[3] && !prevS[d][3]) begin
          checkOutput("dataStableAtSrclkRise", int'(s[2]), int'(prevS[d][2]));
          if (rises[d] > 0) checkOutput("srclkPeriod", gap[d], 2 * divOf(d));
          gap[d] = 0;
          chipSr[d] = {chipSr[d][14:0], s[2]};
          rises[d]++;
        end
        latchRose = s[1] && !prevS[d][1];
        latchFell = !s[1] && prevS[d][1];
        if (latchRose) begin
          checkOutput("bitsPerFrame", rises[d], widthOf(d));
          checkOutput("dataLowInLatch", int'(s[2]), 0);
          mask = 16'((32'd1 << widthOf(d)) - 1);
          parOut[d] = chipSr[d] & mask;
          rises[d] = 0;
          latchW[d] = 0;
          latchPulses[d]++;
        end
        if (s[1]) latchW[d]++;
        if (latchFell) begin
          checkOutput("latchWidth", latchW[d], divOf(d));
          framesDone[d]++;
        end
        checkOutput("frameDonePulse", int'(s[4]), int'(latchFell));
        checkOutput("oenState", int'(s[0]), (framesDone[d] == 0) ? 1 : 0);
      end
      prevS[d] = s;
    end
  end

  task automatic waitReadyA(output int cycles);
    cycles = 0;
    forever begin
      @(posedge clk);
      #1;
      cycles++;
      if (aReady || cycles >= 1000) break;
      dataInA = 16'($urandom);
    end
  endtask

  // Presents one word to instance A and returns the accept-to-ready span.
  task automatic applyStimulus(input logic [15:0] word, input bit keepValid, output int cycles);
    dataInA = word;
    validA = 1'b1;
    @(posedge clk);
    #1;
    if (!keepValid) validA = 1'b0;
    checkOutput("readyDropsOnAccept", int'(aReady), 0);
    waitReadyA(cycles);
    checkOutput("frameDoneWithReady", int'(aDone), 1);
    checkOutput("oenLowAfterFrame", int'(aOen), 0);
  endtask

  initial begin
    vec_t        vecs[5];
    int          cycles;
    int          changes;
    int          pulsesBefore;
    logic [15:0] parBefore;
    logic [5:0]  idleRef;
    logic [15:0] word;

    vecs[0] = '{16'hA5C3, 16'hA5C3, FrameA};
    vecs[1] = '{16'h0000, 16'h0000, FrameA};
    vecs[2] = '{16'hFFFF, 16'hFFFF, FrameA};
    vecs[3] = '{16'h5A5A, 16'h5A5A, FrameA};
    vecs[4] = '{16'h8001, 16'h8001, FrameA};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstReady", int'(aReady), 1);
    checkOutput("rstFrameDone", int'(aDone), 0);
    checkOutput("rstSrclk", int'(aSclk), 0);
    checkOutput("rstSer", int'(aSdata), 0);
    checkOutput("rstLatch", int'(aLatch), 0);
    checkOutput("rstOen", int'(aOen), 1);
    checkOutput("rstReadyB", int'(bReady), 1);
    checkOutput("rstOenB", int'(bOen), 1);

    idleRef = {aReady, aDone, aSclk, aSdata, aLatch, aOen};
    changes = 0;
    repeat (50) begin
      @(negedge clk);
      dataInA = 16'($urandom);
      if ({aReady, aDone, aSclk, aSdata, aLatch, aOen} !== idleRef) changes++;
    end
    checkOutput("idleStatic", changes, 0);
    checkOutput("idleNoLatch", latchPulses[0], 0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].word, 1'b0, cycles);
      checkOutput("frameCycles", cycles, vecs[i].expCycles);
      checkOutput("parallelOut", int'(parOut[0]), int'(vecs[i].expPar));
    end

    applyStimulus(16'h0001, 1'b1, cycles);
    checkOutput("b2bFirstCycles", cycles, FrameA);
    checkOutput("b2bFirstPar", int'(parOut[0]), 16'h0001);
    applyStimulus(16'h8000, 1'b0, cycles);
    checkOutput("b2bSecondCycles", cycles, FrameA);
    checkOutput("b2bSecondPar", int'(parOut[0]), 16'h8000);

    // Abort during the high phase of bit 7, then prove the next frame is clean.
    dataInA = 16'hBEEF;
    validA = 1'b1;
    @(posedge clk);
    #1 validA = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    checkOutput("abortInShiftHi", int'(aSclk), 1);
    pulsesBefore = latchPulses[0];
    parBefore = parOut[0];
    reset = 1'b1;
    #1;
    checkOutput("abortSrclk", int'(aSclk), 0);
    checkOutput("abortSer", int'(aSdata), 0);
    checkOutput("abortLatch", int'(aLatch), 0);
    checkOutput("abortOen", int'(aOen), 1);
    checkOutput("abortReady", int'(aReady), 1);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abortNoLatch", latchPulses[0], pulsesBefore);
    checkOutput("abortParHeld", int'(parOut[0]), int'(parBefore));
    checkOutput("abortOenStill", int'(aOen), 1);
    applyStimulus(16'h1234, 1'b0, cycles);
    checkOutput("postAbortCycles", cycles, FrameA);
    checkOutput("postAbortPar", int'(parOut[0]), 16'h1234);

    for (int i = 0; i < 8; i++) begin
      word = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      applyStimulus(word, 1'b0, cycles);
      checkOutput("randCycles", cycles, FrameA);
      checkOutput("randPar", int'(parOut[0]), int'(word));
    end

    dataInB = 8'h81;
    validB = 1'b1;
    @(posedge clk);
    #1;
    validB = 1'b0;
    dataInB = 8'h7E;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bReady && cycles < 200);
    checkOutput("div1Cycles", cycles, FrameB);
    checkOutput("div1Par", int'(parOut[1]), 8'h81);
    checkOutput("div1Done", int'(bDone), 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
